// File: rtl/des_pkg.sv
// Shared FSM state encoding and block width for the DES block feeder.
package des_pkg;
   localparam int unsigned BLK_W = 64;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RELEASE = 2'd2,
      ST_OUT     = 2'd3
   } state_t;
endpackage

// File: rtl/des_byte_packer.sv
// Packs 8 accepted bytes MSB-first into a 64-bit block; full_o pulses on the 8th byte.
// blk_o is the register's next value, so on the full_o cycle it already holds the complete block.
module des_byte_packer
   import des_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld_i,
   input  logic             rdy_i,
   input  logic [7:0]       byte_i,
   output logic [BLK_W-1:0] blk_o,
   output logic             full_o
);

   logic [BLK_W-1:0] sr_q, sr_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             acc;

   always_comb begin
      acc   = vld_i & rdy_i;
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (acc) begin
         sr_d  = {sr_q[BLK_W-9:0], byte_i};
         cnt_d = cnt_q + 3'd1;
      end
   end

   assign blk_o  = sr_d;
   assign full_o = acc & (cnt_q == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/des_block_feeder.sv
// Byte-stream to DES-core block feeder: FILL -> RUN -> RELEASE -> OUT, with RUN timeout; 8th byte to out_valid >= core latency + 2.
// Stalls input while a block is in flight or held on out_ready; DES_CBC_EN selects CBC chaining (ECB otherwise).
module des_block_feeder
   import des_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   input  logic             iv_load,
   input  logic [BLK_W-1:0] iv,
   output logic             core_start,
   output logic [BLK_W-1:0] core_desIn,
   input  logic             core_ready,
   input  logic [BLK_W-1:0] core_desOut,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             err_timeout
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_t           state_q, state_d;
   logic             live_q;
   logic [BLK_W-1:0] din_q, din_d;
   logic [BLK_W-1:0] dout_q, dout_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             full;
   logic             capture;
   logic [BLK_W-1:0] blk;
   logic [BLK_W-1:0] chain_sel;

   assign in_ready    = (state_q == ST_FILL) & live_q;
   assign capture     = (state_q == ST_RUN) & core_ready;
   assign core_desIn  = din_q;
   assign out_data    = dout_q;
   assign err_timeout = err_q;

   des_byte_packer u_packer (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (in_valid),
      .rdy_i  (in_ready),
      .byte_i (in_byte),
      .blk_o  (blk),
      .full_o (full)
   );

`ifdef DES_CBC_EN
   logic [BLK_W-1:0] chain_q, chain_d;

   // A fresh iv beats both the stored chain and a same-cycle capture.
   assign chain_sel = iv_load ? iv : chain_q;

   always_comb begin
      chain_d = chain_q;
      if (capture) chain_d = core_desOut;
      if (iv_load) chain_d = iv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= chain_d;
   end
`else
   logic unused_iv;
   assign unused_iv = &{1'b0, iv_load, iv};
   assign chain_sel = '0;
`endif

   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      dout_d     = dout_q;
      tmo_d      = '0;
      err_d      = err_q;
      core_start = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (full) begin
               din_d   = blk ^ chain_sel;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            core_start = 1'b1;
            if (core_ready) begin
               dout_d  = core_desOut;
               state_d = ST_RELEASE;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_FILL;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         // Wait for the core to drop ready so start is never raised into a stale result.
         ST_RELEASE: begin
            if (!core_ready) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         live_q  <= 1'b0;
         din_q   <= '0;
         dout_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         din_q   <= din_d;
         dout_q  <= dout_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_des_block_feeder.sv
// Randomized bench for des_block_feeder with a stub DES core and a block-level reference model.
module tb_des_block_feeder;

   localparam int TMO = 64;
   localparam logic [63:0] KAT_PT = 64'h0123456789ABCDEF;
   localparam logic [63:0] KAT_CT = 64'h85E813540F0AB405;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        iv_load = 1'b0;
   logic [63:0] iv = 64'h0;
   logic        core_ready = 1'b0;
   logic [63:0] core_desOut = 64'h0;
   logic        out_ready = 1'b0;
   logic        in_ready, core_start, out_valid, err_timeout;
   logic [63:0] core_desIn, out_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   des_block_feeder #(.TIMEOUT_CYC(TMO)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_byte     (in_byte),
      .iv_load     (iv_load),
      .iv          (iv),
      .core_start  (core_start),
      .core_desIn  (core_desIn),
      .core_ready  (core_ready),
      .core_desOut (core_desOut),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .err_timeout (err_timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Stub cipher: known answer for the reference block, otherwise an arbitrary bijection.
   function automatic logic [63:0] core_fn(input logic [63:0] x);
      if (x == KAT_PT) return KAT_CT;
      return {x[40:0], x[63:41]} ^ 64'hC3A5_5A3C_0FF0_9669;
   endfunction

   // Stub core and monitor on start rising edges
   bit          stuck = 0;
   bit          start_prev = 0;
   int          core_lat = 0, rel_dly = 0, lat_cnt = 0, rel_cnt = 0;
   logic [63:0] exp_desin = 64'h0;
   logic [63:0] chain_m = 64'h0;

   always @(negedge clk) begin
      if (core_start && !start_prev) begin
         check("start_while_ready", {63'h0, core_ready}, 64'h0);
         check("core_desIn", core_desIn, exp_desin);
      end
      start_prev = core_start;
      if (stuck) begin
         core_ready = 1'b0;
         lat_cnt = 0;
      end else if (!core_ready) begin
         if (core_start) begin
            if (lat_cnt >= core_lat) begin
               core_ready  = 1'b1;
               core_desOut = core_fn(core_desIn);
               lat_cnt = 0;
            end else lat_cnt++;
         end else lat_cnt = 0;
      end else if (!core_start) begin
         if (rel_cnt >= rel_dly) begin
            core_ready = 1'b0;
            rel_cnt = 0;
         end else rel_cnt++;
      end
   end

   task automatic send_bytes(input logic [63:0] blk, input int n, input int gap_max,
                             input bit iv_at_end, input logic [63:0] ivv);
      int g, t;
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(gap_max, 0);
         repeat (g) @(negedge clk);
         in_valid = 1'b1;
         in_byte  = blk[63-8*i -: 8];
         if (i == 7 && iv_at_end) begin
            iv_load = 1'b1;
            iv      = ivv;
         end
         t = 0;
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (t >= 300) check("in_ready_wait", 64'h0, 64'h1);
         @(negedge clk);
         in_valid = 1'b0;
         iv_load  = 1'b0;
      end
   endtask

   task automatic do_block(input string tag, input logic [63:0] blk, input int gap_max,
                           input int hold, input bit iv_at_end, input logic [63:0] ivv);
      logic [63:0] exp_out, first;
      int t, bad;
`ifdef DES_CBC_EN
      exp_desin = blk ^ (iv_at_end ? ivv : chain_m);
`else
      exp_desin = blk;
`endif
      exp_out  = core_fn(exp_desin);
      core_lat = $urandom_range(4, 0);
      rel_dly  = $urandom_range(2, 0);
      send_bytes(blk, 8, gap_max, iv_at_end, ivv);
      t = 0;
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check({tag, "_out_valid_wait"}, 64'h0, 64'h1);
      first = out_data;
      bad = 0;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         if (out_data !== first || in_ready || core_start || !out_valid) bad++;
      end
      if (hold > 0) check({tag, "_backpressure"}, bad, 0);
      check({tag, "_out_data"}, out_data, exp_out);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, {63'h0, out_valid}, 64'h0);
      check({tag, "_in_ready_back"}, {63'h0, in_ready}, 64'h1);
`ifdef DES_CBC_EN
      chain_m = exp_out;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {63'h0, in_ready}, 64'h0);
      check("rst_core_start", {63'h0, core_start}, 64'h0);
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_err", {63'h0, err_timeout}, 64'h0);
      check("rst_out_data", out_data, 64'h0);
      check("rst_core_desIn", core_desIn, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      chain_m = 64'h0;
      @(negedge clk);
      check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
   endtask

   initial begin
      int runc, t;
      logic [63:0] r;
      repeat (2) @(negedge clk);
      do_reset();

      do_block("kat", KAT_PT, 0, 0, 0, 64'h0);
      do_block("kat2", KAT_PT, 0, 0, 0, 64'h0);
      do_block("kat_gaps", KAT_PT, 3, 0, 0, 64'h0);
      do_block("bp", {$urandom, $urandom}, 1, 20, 0, 64'h0);

      for (int b = 0; b < 10; b++) begin
         r = {$urandom, $urandom};
`ifdef DES_CBC_EN
         if (b % 3 == 1) begin
            do_block("rnd_iv", r, 2, $urandom_range(3, 0), 1, {$urandom, $urandom});
         end else if (b % 3 == 2) begin
            @(negedge clk);
            iv_load = 1'b1;
            iv = {$urandom, $urandom};
            chain_m = iv;
            @(negedge clk);
            iv_load = 1'b0;
            do_block("rnd_ividle", r, 2, $urandom_range(3, 0), 0, 64'h0);
         end else
`endif
         do_block("rnd", r, 2, $urandom_range(3, 0), 0, 64'h0);
      end

      // Stuck core: RUN must last exactly TMO cycles, then error and back to FILL.
      stuck = 1;
      exp_desin = `ifdef DES_CBC_EN KAT_PT ^ chain_m `else KAT_PT `endif;
      send_bytes(KAT_PT, 8, 0, 0, 64'h0);
      runc = 0;
      t = 0;
      while (!err_timeout && t < 300) begin
         if (core_start) runc++;
         @(negedge clk);
         t++;
      end
      check("tmo_run_cycles", runc, TMO);
      check("tmo_err", {63'h0, err_timeout}, 64'h1);
      check("tmo_fill", {63'h0, in_ready}, 64'h1);
      check("tmo_no_out", {63'h0, out_valid}, 64'h0);
      stuck = 0;
      do_block("after_tmo", {$urandom, $urandom}, 1, 0, 0, 64'h0);
      check("err_sticky", {63'h0, err_timeout}, 64'h1);

      // Partial block abandoned by reset
      send_bytes(64'hDEADBEEF_CAFEF00D, 5, 1, 0, 64'h0);
      do_reset();
      do_block("fresh", KAT_PT, 0, 0, 0, 64'h0);
      do_block("fresh_rnd", {$urandom, $urandom}, 2, 2, 0, 64'h0);
      check("err_after_reset", {63'h0, err_timeout}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
